// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq -- host-side command sequencer for the DSO UART link.
//
// Sends a CMD_BYTES-wide command through a UART transceiver, most significant
// byte first. It then collects resp_len response bytes and presents each one
// as a single-cycle stream beat.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd, resp_len       command word and response byte count (0 = none), latched on send_cmd
//   send_cmd            start pulse, honoured only while idle
//   busy                high from the accepted send_cmd until the end of the transaction
//   cmd_sent            pulse once the last command byte reports tx_done
//   resp_data/vld/last  response stream; resp_last marks the final byte
//   done                pulse at the end of the transaction
//   ack_ok              level: single-byte response equal to ACK_VAL, held until next send_cmd
//   timeout             pulse when a transaction is aborted for inactivity
//   tx_data, trmt       byte and strobe to the UART transmitter
//   tx_done             transmitter-complete level (rising edge is used)
//   rx_data, rx_rdy     received byte and ready level from the UART receiver
//   clr_rx_rdy          pulse that clears rx_rdy in the receiver
//
// Build option: define RESP_TIMEOUT_EN to abort after TIMEOUT_CYC idle cycles
// in TX_WAIT or RESP. When it is not defined, timeout is tied low and the
// sequencer waits indefinitely.

module uart_cmd_seq #(
   parameter int unsigned CMD_BYTES   = 3,
   parameter int unsigned LEN_W       = 16,
   parameter logic [7:0]  ACK_VAL     = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [8*CMD_BYTES-1:0] cmd,
   input  logic [LEN_W-1:0]       resp_len,
   input  logic                   send_cmd,
   output logic                   busy,
   output logic                   cmd_sent,
   output logic [7:0]             resp_data,
   output logic                   resp_vld,
   output logic                   resp_last,
   output logic                   done,
   output logic                   ack_ok,
   output logic                   timeout,
   output logic [7:0]             tx_data,
   output logic                   trmt,
   input  logic                   tx_done,
   input  logic [7:0]             rx_data,
   input  logic                   rx_rdy,
   output logic                   clr_rx_rdy
);

   // state     | meaning
   // S_IDLE    | waiting for send_cmd
   // S_LOAD    | present next command byte, strobe trmt
   // S_TX_WAIT | waiting for tx_done rising edge
   // S_RESP    | collecting response bytes
   // S_DONE    | issue done, return to idle

   localparam int unsigned CMD_W  = 8 * CMD_BYTES;
   localparam int unsigned BCNT_W = $clog2(CMD_BYTES + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TX_WAIT, S_RESP, S_DONE} state_t;

   state_t             state_q;
   logic [CMD_W-1:0]   shadow_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   resp_cnt_q;
   logic [BCNT_W-1:0]  byte_cnt_q;
   logic               tx_done_q;
   logic               rx_skip_q;
   logic               tx_rise;

   assign tx_rise = tx_done & ~tx_done_q;

`ifdef RESP_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0]   tmo_cnt_q;
   logic               tmo_hit;
   assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         shadow_q   <= '0;
         len_q      <= '0;
         resp_cnt_q <= '0;
         byte_cnt_q <= '0;
         tx_done_q  <= 1'b0;
         rx_skip_q  <= 1'b0;
         busy       <= 1'b0;
         cmd_sent   <= 1'b0;
         resp_data  <= '0;
         resp_vld   <= 1'b0;
         resp_last  <= 1'b0;
         done       <= 1'b0;
         ack_ok     <= 1'b0;
         tx_data    <= '0;
         trmt       <= 1'b0;
         clr_rx_rdy <= 1'b0;
`ifdef RESP_TIMEOUT_EN
         tmo_cnt_q  <= '0;
         timeout    <= 1'b0;
`endif
      end else begin
         tx_done_q  <= tx_done;
         trmt       <= 1'b0;
         cmd_sent   <= 1'b0;
         resp_vld   <= 1'b0;
         resp_last  <= 1'b0;
         clr_rx_rdy <= 1'b0;
         done       <= 1'b0;
         rx_skip_q  <= 1'b0;
`ifdef RESP_TIMEOUT_EN
         // Cleared unless a waiting state keeps it running this cycle.
         timeout    <= 1'b0;
         tmo_cnt_q  <= '0;
`endif
         unique case (state_q)
            S_IDLE: begin
               if (send_cmd) begin
                  shadow_q   <= cmd;
                  len_q      <= resp_len;
                  resp_cnt_q <= resp_len;
                  byte_cnt_q <= '0;
                  ack_ok     <= 1'b0;
                  busy       <= 1'b1;
                  state_q    <= S_LOAD;
               end
            end
            S_LOAD: begin
               tx_data    <= shadow_q[CMD_W-1 -: 8];
               trmt       <= 1'b1;
               shadow_q   <= shadow_q << 8;
               byte_cnt_q <= byte_cnt_q + 1'b1;
               state_q    <= S_TX_WAIT;
            end
            S_TX_WAIT: begin
               if (tx_rise) begin
                  if (byte_cnt_q == BCNT_W'(CMD_BYTES)) begin
                     cmd_sent <= 1'b1;
                     state_q  <= (len_q == '0) ? S_DONE : S_RESP;
                  end else begin
                     state_q  <= S_LOAD;
                  end
               end
`ifdef RESP_TIMEOUT_EN
               else if (tmo_hit) begin
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
`endif
            end
            S_RESP: begin
               // rx_rdy is still high the cycle after clr_rx_rdy, so skip it once.
               if (!rx_skip_q && rx_rdy) begin
                  resp_data  <= rx_data;
                  resp_vld   <= 1'b1;
                  clr_rx_rdy <= 1'b1;
                  rx_skip_q  <= 1'b1;
                  resp_cnt_q <= resp_cnt_q - 1'b1;
                  if (len_q == LEN_W'(1) && rx_data == ACK_VAL) begin
                     ack_ok <= 1'b1;
                  end
                  if (resp_cnt_q == LEN_W'(1)) begin
                     resp_last <= 1'b1;
                     state_q   <= S_DONE;
                  end
               end
`ifdef RESP_TIMEOUT_EN
               else if (tmo_hit) begin
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
`endif
            end
            S_DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
